// File: rtl/pc_sequencer.sv
// Two-phase (FETCH/EXEC) program-counter sequencer: it fetches an instruction word,
// steps the decoder micro-state, and updates the PC when the instruction retires.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [1:0]  state,
  input  logic [1:0]  nextState,
  input  logic [1:0]  Psel,
  input  logic        PCsel,
  input  logic [63:0] K,
  input  logic [63:0] reg_in,
  output logic [63:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        align_err
);

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

  logic        phase_q, phase_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        aerr_q, aerr_d;

  logic [63:0] offset;
  logic [63:0] target;

  assign pc_plus4    = pc_q + 64'd4;
  assign imem_req    = (phase_q == PH_FETCH);
  assign imem_addr   = pc_q;
  assign instruction = ir_q;
  assign state       = state_q;
  assign instr_count = count_q;
  assign align_err   = aerr_q;

  // Retire target; offsets are word counts, so they are scaled by 4 before adding.
  always_comb begin
    offset = PCsel ? K : reg_in;
    case (Psel)
      2'b00:   target = pc_q;
      2'b01:   target = pc_plus4;
      2'b10:   target = reg_in;
      default: target = pc_plus4 + (offset << 2);
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    state_d = state_q;
    count_d = count_q;
    aerr_d  = aerr_q;
    if (phase_q == PH_FETCH) begin
      if (imem_ack) begin
        ir_d    = imem_data;
        state_d = 2'b00;
        phase_d = PH_EXEC;
      end
    end else if (nextState != 2'b00) begin
      state_d = nextState;
    end else begin
      // A misaligned target is still taken, rounded down, and flagged until reset.
      pc_d    = {target[63:2], 2'b00};
      count_d = count_q + 32'd1;
      state_d = 2'b00;
      phase_d = PH_FETCH;
      if (target[1:0] != 2'b00) begin
        aerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      state_q <= 2'b00;
      count_q <= 32'h0;
      aerr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      state_q <= state_d;
      count_q <= count_d;
      aerr_q  <= aerr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run, all
// compared against a plain behavioural model of fetch / execute / retire.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [1:0]  nextState;
  logic [1:0]  Psel;
  logic        PCsel;
  logic [63:0] K;
  logic [63:0] reg_in;
  logic [63:0] pc_plus4;
  logic [31:0] instr_count;
  logic        align_err;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: "waiting" is true while an instruction word is still being fetched.
  bit          mWaiting;
  logic [63:0] mPc;
  logic [31:0] mIr;
  logic [1:0]  mState;
  logic [31:0] mCount;
  bit          mAlignErr;

  pc_sequencer #(.RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instruction(instruction), .state(state), .nextState(nextState),
    .Psel(Psel), .PCsel(PCsel), .K(K), .reg_in(reg_in),
    .pc_plus4(pc_plus4), .instr_count(instr_count), .align_err(align_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".imem_req"},    {63'd0, imem_req},  {63'd0, mWaiting});
    checkValue({tag, ".imem_addr"},   imem_addr,          mPc);
    checkValue({tag, ".instruction"}, {32'd0, instruction}, {32'd0, mIr});
    checkValue({tag, ".state"},       {62'd0, state},     {62'd0, mState});
    checkValue({tag, ".pc_plus4"},    pc_plus4,           mPc + 64'd4);
    checkValue({tag, ".instr_count"}, {32'd0, instr_count}, {32'd0, mCount});
    checkValue({tag, ".align_err"},   {63'd0, align_err}, {63'd0, mAlignErr});
  endtask

  task automatic modelReset();
    mWaiting  = 1'b1;
    mPc       = 64'h0;
    mIr       = 32'h0;
    mState    = 2'b00;
    mCount    = 32'h0;
    mAlignErr = 1'b0;
  endtask

  // One clock of the architectural behaviour, evaluated with the inputs present at the edge.
  task automatic modelEdge();
    logic [63:0] dest;
    logic [63:0] off;
    if (mWaiting) begin
      if (imem_ack) begin
        mIr      = imem_data;
        mState   = 2'b00;
        mWaiting = 1'b0;
      end
    end else if (nextState != 2'b00) begin
      mState = nextState;
    end else begin
      off = PCsel ? K : reg_in;
      if (Psel == 2'd0)      dest = mPc;
      else if (Psel == 2'd1) dest = mPc + 64'd4;
      else if (Psel == 2'd2) dest = reg_in;
      else                   dest = mPc + 64'd4 + off * 64'd4;
      if (dest % 64'd4 != 64'd0) begin
        mAlignErr = 1'b1;
        dest      = dest - (dest % 64'd4);
      end
      mPc      = dest;
      mCount   = mCount + 32'd1;
      mState   = 2'b00;
      mWaiting = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic [1:0] ns,
                               input logic [1:0] psel, input logic pcsel,
                               input logic [63:0] k, input logic [63:0] rin, input string tag);
    imem_ack  = ack;
    imem_data = data;
    nextState = ns;
    Psel      = psel;
    PCsel     = pcsel;
    K         = k;
    reg_in    = rin;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic fetchWord(input logic [31:0] data, input string tag);
    applyStimulus(1'b1, data, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0, tag);
  endtask

  task automatic retire(input logic [1:0] psel, input logic pcsel, input logic [63:0] k,
                        input logic [63:0] rin, input string tag);
    applyStimulus(1'b0, 32'h0, 2'b00, psel, pcsel, k, rin, tag);
  endtask

  initial begin
    reset = 1'b0;
    imem_ack = 1'b0; imem_data = 32'h0; nextState = 2'b00;
    Psel = 2'b00; PCsel = 1'b0; K = 64'h0; reg_in = 64'h0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clock);
    #1;
    checkOutput("resetHeld");
    #2 reset = 1'b1;

    // Sequential flow
    fetchWord(32'h8B020020, "seqFetch");
    checkValue("seqIr", {32'd0, instruction}, 64'h8B020020);
    retire(2'b01, 1'b0, 64'h0, 64'h0, "seqRetire");
    checkValue("seqPc", imem_addr, 64'h4);
    checkValue("seqCount", {32'd0, instr_count}, 64'd1);
    checkValue("seqReq", {63'd0, imem_req}, 64'd1);

    // Conditional branch taken and not taken from 0x100
    fetchWord(32'h11111111, "jmpFetch");
    retire(2'b10, 1'b0, 64'h0, 64'h100, "jmpRetire");
    fetchWord(32'hB4000040, "brFetch");
    retire(2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, "brTaken");
    checkValue("brTakenPc", imem_addr, 64'hFC);
    fetchWord(32'h22222222, "jmp2Fetch");
    retire(2'b10, 1'b0, 64'h0, 64'h100, "jmp2Retire");
    fetchWord(32'hB4000040, "brFetch2");
    retire(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, "brNotTaken");
    checkValue("brNotTakenPc", imem_addr, 64'h104);

    // Multi-cycle instruction; Psel is live during the non-retire cycles to show it is ignored
    fetchWord(32'h33333333, "mcFetch");
    checkValue("mcState0", {62'd0, state}, 64'd0);
    applyStimulus(1'b1, 32'hDEAD0000, 2'b01, 2'b10, 1'b0, 64'h0, 64'h800, "mcExec1");
    checkValue("mcState1", {62'd0, state}, 64'd1);
    applyStimulus(1'b0, 32'h0, 2'b10, 2'b11, 1'b1, 64'h10, 64'h800, "mcExec2");
    checkValue("mcState2", {62'd0, state}, 64'd2);
    retire(2'b01, 1'b0, 64'h0, 64'h0, "mcRetire");

    // Fetch stall for five cycles, then ack
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'hBADBAD00 + i, 2'b00, 2'b01, 1'b0, 64'h0, 64'h0, "stall");
    end
    checkValue("stallReq", {63'd0, imem_req}, 64'd1);
    fetchWord(32'h44444444, "stallAck");
    checkValue("stallIr", {32'd0, instruction}, 64'h44444444);

    // Misaligned target, then a later retire keeps the flag
    retire(2'b10, 1'b0, 64'h0, 64'h203, "misRetire");
    checkValue("misPc", imem_addr, 64'h200);
    checkValue("misFlag", {63'd0, align_err}, 64'd1);
    fetchWord(32'h55555555, "misFetch2");
    retire(2'b01, 1'b0, 64'h0, 64'h0, "misRetire2");

    // PC wrap past the top of the address space
    fetchWord(32'h66666666, "wrapFetch");
    retire(2'b10, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, "wrapJump");
    fetchWord(32'h77777777, "wrapFetch2");
    retire(2'b01, 1'b0, 64'h0, 64'h0, "wrapRetire");
    checkValue("wrapPc", imem_addr, 64'h0);

    // Asynchronous reset between edges while in EXEC with a retire pending
    fetchWord(32'h88888888, "arFetch");
    nextState = 2'b00; Psel = 2'b01;
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset");
    @(posedge clock);
    #1;
    checkOutput("asyncResetHeld");
    #2 reset = 1'b1;

    // Randomized run
    for (int i = 0; i < 300; i++) begin
      logic        rAck;
      logic [1:0]  rNs;
      logic [63:0] rRin;
      rAck = ($urandom_range(0, 3) != 0);
      rNs  = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
      rRin = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rRin[1:0] = 2'b00;
      applyStimulus(rAck, $urandom, rNs, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, rRin, "random");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC value loaded on reset.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory fetch request.
REQ-005 imem_addr  output  64  fetch address; always equals the PC register.
REQ-006 imem_ack  input  1  fetch complete; imem_data valid in the same cycle.
REQ-007 imem_data  input  32  fetched instruction word.
REQ-008 instruction  output  32  instruction register (IR), fed to the decoders.
REQ-009 state  output  2  current micro-state, fed to the decoders.
REQ-010 nextState  input  2  decoder-requested micro-state.
REQ-011 Psel  input  2  PC update select from the control word.
REQ-012 PCsel  input  1  branch-offset source: 1 = K, 0 = reg_in.
REQ-013 K  input  64  sign-extended immediate from the decoder.
REQ-014 reg_in  input  64  register-file value for absolute or register-relative targets.
REQ-015 pc_plus4  output  64  PC + 4, combinational.
REQ-016 instr_count  output  32  count of retired instructions.
REQ-017 align_err  output  1  sticky flag for a misaligned PC target.

Function
REQ-018 The block SHALL be a two-phase FSM with phases FETCH and EXEC.
REQ-019 FETCH: imem_req SHALL be 1. On a clock edge with imem_ack=1: IR <= imem_data, state <= 2'b00, phase <= EXEC. With imem_ack=0, the block SHALL hold.
REQ-020 EXEC: imem_req SHALL be 0, and imem_ack SHALL be ignored.
REQ-021 EXEC with nextState != 2'b00: state <= nextState; PC, IR and instr_count SHALL hold. Psel SHALL be ignored.
REQ-022 EXEC with nextState == 2'b00 (retire cycle): the PC SHALL update per Psel. instr_count SHALL increment by 1. state <= 2'b00 and phase <= FETCH.
REQ-023 Psel encoding at retire, where PC is the retiring instruction's address:
  - 00: PC holds (re-fetch the same address).
  - 01: PC + 4.
  - 10: reg_in.
  - 11: PC + 4 + (off << 2), where off = PCsel ? K : reg_in.
REQ-024 All PC arithmetic SHALL be 64-bit modulo 2^64. Wrap past 64'hFFFF_FFFF_FFFF_FFFC SHALL be silent.
REQ-025 If a retire target has bits [1:0] != 0, the PC SHALL load the target with bits [1:0] forced to 00, and align_err SHALL set.
REQ-026 align_err SHALL clear only on reset.
REQ-027 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 Minimum instruction latency SHALL be 2 cycles: 1 FETCH cycle with an immediate ack, plus 1 EXEC cycle.
REQ-029 A one-cycle instruction presents state=00. A multi-cycle instruction sees state follow nextState each EXEC cycle.
REQ-030 Outputs imem_req, imem_addr, instruction, state, instr_count and align_err SHALL be registered, or decoded from registered phase only. pc_plus4 SHALL be a combinational function of the PC register.

Reset
REQ-031 On reset assertion, regardless of clock, the block SHALL set:
  - phase = FETCH
  - PC = RESET_PC
  - IR = 32'h0
  - state = 2'b00
  - instr_count = 0
  - align_err = 0
REQ-032 In reset, imem_req SHALL read 1 and imem_addr SHALL read RESET_PC.
REQ-033 Reset mid-fetch or mid-EXEC SHALL abandon the instruction without retiring it or counting it.
REQ-034 After reset deasserts, the first rising edge SHALL be treated as a normal FETCH cycle.

Verification
REQ-035 Sequential flow: reset; imem_ack=1 with data 32'h8B020020; in EXEC drive nextState=00, Psel=01 -> PC goes 0 -> 4, instr_count=1, imem_req re-asserts.
REQ-036 Conditional branch taken: PC=0x100; Psel=11, PCsel=1, K=64'hFFFF_FFFF_FFFF_FFFE -> PC = 0x100+4-8 = 0xFC. Not taken: Psel=01 -> PC = 0x104.
REQ-037 Multi-cycle instruction: nextState driven 01, then 10, then 00 -> state output shows 00, 01, 10; PC and instr_count change only on the third EXEC edge.
REQ-038 Fetch stall: hold imem_ack=0 for 5 cycles -> imem_req stays 1, imem_addr is stable, IR unchanged; ack on cycle 6 -> IR loads.
REQ-039 Misaligned target: Psel=10, reg_in=0x203 -> PC = 0x200 and align_err = 1, persisting over later retires until reset.
REQ-040 Wrap and async reset: PC=64'hFFFF_FFFF_FFFF_FFFC with Psel=01 -> PC = 0. Then assert reset mid-EXEC between clock edges -> outputs reach reset values immediately, and instr_count does not increment.
